// File: rtl/pd_pkg.sv
// Shared widths and decision threshold for the Mueller-Muller phase detector.
package pd_pkg;

  localparam int PD_THRESH = 0;

  function automatic int pd_term_w(input int nadc);
    return nadc + 2;
  endfunction

  function automatic int pd_out_w(input int nadc, input int nti, input int nacc);
    return nadc + 2 + $clog2(nti) + nacc;
  endfunction

endpackage

// File: rtl/pd_mm_slice.sv
// One sign-data Mueller-Muller term for a single interleaved slice.
module pd_mm_slice
  import pd_pkg::*;
#(
  parameter int Nadc = 8,
  localparam int TW = pd_term_w(Nadc)
) (
  input  logic signed [Nadc-1:0] y,
  input  logic signed [Nadc-1:0] yp,
  input  logic                   yp_valid,
  input  logic signed [Nadc-1:0] offset,
  output logic signed [TW-1:0]   t
);

  localparam logic signed [Nadc-1:0] TH = Nadc'(PD_THRESH);

  logic signed [TW-1:0] ye;
  logic signed [TW-1:0] ype;
  logic signed [TW-1:0] a_t;
  logic signed [TW-1:0] b_t;

  always_comb begin
    ye  = TW'(y);
    ype = TW'(yp);
    a_t = (yp >= TH) ? ye : -ye;
    b_t = (y >= TH) ? ype : -ype;
    t   = yp_valid ? (a_t - b_t + TW'(offset)) : '0;
  end

endmodule

// File: rtl/pd_main_mm.sv
// Main MM phase detector: per-slice terms, word sum and windowed
// accumulation into a signed phase-error word with a valid strobe.
module pd_main_mm
  import pd_pkg::*;
#(
  parameter int Nadc = 8,
  parameter int Nti  = 1,
  parameter int Nacc = 4,
  localparam int PW = pd_out_w(Nadc, Nti, Nacc)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [Nadc-1:0] din [Nti-1:0],
  input  logic signed [Nadc-1:0] pd_offset,
  input  logic                   hold,
  output logic signed [PW-1:0]   pd_out,
  output logic                   pd_valid
);

  localparam int TW = pd_term_w(Nadc);
  localparam int SW = TW + $clog2(Nti);
  localparam int CW = (Nacc > 0) ? Nacc : 1;
  localparam logic [CW-1:0] LAST = CW'((1 << Nacc) - 1);

  logic signed [Nadc-1:0] d1 [Nti-1:0];
  logic signed [Nadc-1:0] off1;
  logic signed [Nadc-1:0] hp1;
  logic                   hv1;
  logic                   v1;
  logic signed [Nadc-1:0] hist;
  logic                   hist_v;

  logic signed [TW-1:0] t [Nti-1:0];
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] wsum;
  logic                 v2;

  logic signed [PW-1:0] acc;
  logic signed [PW-1:0] acc_nx;
  logic [CW-1:0]        cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < Nti; k++) d1[k] <= '0;
      off1   <= '0;
      hp1    <= '0;
      hv1    <= 1'b0;
      v1     <= 1'b0;
      hist   <= '0;
      hist_v <= 1'b0;
    end else begin
      d1   <= din;
      off1 <= pd_offset;
      hp1  <= hist;
      hv1  <= hist_v;
      v1   <= !hold;
      // a held word breaks the sample chain for the next slice 0
      if (hold) begin
        hist_v <= 1'b0;
      end else begin
        hist   <= din[Nti-1];
        hist_v <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < Nti; k++) begin : g_slice
    if (k == 0) begin : g_first
      pd_mm_slice #(.Nadc(Nadc)) u_slice (
        .y(d1[0]), .yp(hp1), .yp_valid(hv1),
        .offset(off1), .t(t[0])
      );
    end else begin : g_rest
      pd_mm_slice #(.Nadc(Nadc)) u_slice (
        .y(d1[k]), .yp(d1[k-1]), .yp_valid(1'b1),
        .offset(off1), .t(t[k])
      );
    end
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < Nti; k++) sum = sum + SW'(t[k]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wsum <= '0;
      v2   <= 1'b0;
    end else begin
      wsum <= sum;
      v2   <= v1;
    end
  end

  assign acc_nx = acc + PW'(wsum);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      pd_out   <= '0;
      pd_valid <= 1'b0;
    end else if (!v2) begin
      pd_valid <= 1'b0;
    end else if (cnt == LAST) begin
      pd_out   <= acc_nx;
      acc      <= '0;
      cnt      <= '0;
      pd_valid <= 1'b1;
    end else begin
      acc      <= acc_nx;
      cnt      <= cnt + 1'b1;
      pd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pd_main_mm.sv
// Bench for pd_main_mm at Nti=2, Nacc=2 against a word-level model.
module tb_pd_main_mm;

  localparam int NADC = 8;
  localparam int NTI  = 2;
  localparam int NACC = 2;
  localparam int PW   = NADC + 2 + 1 + NACC;
  localparam int WIN  = 1 << NACC;

  logic                   clk;
  logic                   rst;
  logic signed [NADC-1:0] din [NTI-1:0];
  logic signed [NADC-1:0] pd_offset;
  logic                   hold;
  logic signed [PW-1:0]   pd_out;
  logic                   pd_valid;

  int checks = 0;
  int failures = 0;

  pd_main_mm #(.Nadc(NADC), .Nti(NTI), .Nacc(NACC)) dut (
    .clk(clk), .rst(rst), .din(din), .pd_offset(pd_offset),
    .hold(hold), .pd_out(pd_out), .pd_valid(pd_valid)
  );

  always #5 clk = ~clk;

  // word-level model: windows of accepted words, result due two edges later
  int n = 0;
  int m_acc, m_cnt, m_hist;
  bit m_hv;
  int sched [int];
  bit m_valid;
  int m_out;

  function automatic int term(input int yp, input int y, input int off);
    int a, b;
    a = (yp >= 0) ? y : -y;
    b = (y >= 0) ? yp : -yp;
    return a - b + off;
  endfunction

  function automatic int rnd8();
    return int'($urandom_range(255)) - 128;
  endfunction

  task automatic tick(input int a0, input int a1, input int off,
                      input bit h, input bit r);
    int w;
    int keys [$];
    din[0] = NADC'(a0);
    din[1] = NADC'(a1);
    pd_offset = NADC'(off);
    hold = h;
    rst = r;
    @(posedge clk);
    n++;
    if (r) begin
      m_acc = 0;
      m_cnt = 0;
      m_hv = 0;
      m_out = 0;
      foreach (sched[k]) if (k >= n) keys.push_back(k);
      foreach (keys[i]) sched.delete(keys[i]);
    end else if (h) begin
      m_hv = 0;
    end else begin
      w = (m_hv ? term(m_hist, a0, off) : 0) + term(a0, a1, off);
      m_hist = a1;
      m_hv = 1;
      if (m_cnt == WIN - 1) begin
        sched[n + 2] = m_acc + w;
        m_acc = 0;
        m_cnt = 0;
      end else begin
        m_acc += w;
        m_cnt++;
      end
    end
    m_valid = 0;
    if (sched.exists(n)) begin
      m_valid = 1;
      m_out = sched[n];
      sched.delete(n);
    end
    #1;
  endtask

  task automatic test_reset();
    int base, first;
    first = -1;
    for (int i = 0; i < 2; i++) begin
      tick(rnd8(), rnd8(), rnd8(), 1'b0, 1'b1);
      checks++;
      if (pd_out !== '0 || pd_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_state: pd_out=%0d pd_valid=%0b expected 0 0",
                 pd_out, pd_valid);
      end
    end
    base = n;
    for (int i = 0; i < 8; i++) begin
      tick(20, 20, 0, 1'b0, 1'b0);
      checks++;
      if (pd_valid !== m_valid || pd_out !== PW'(m_out)) begin
        failures++;
        $display("FAIL reset_model: pd_valid=%0b pd_out=%0d expected %0b %0d",
                 pd_valid, pd_out, m_valid, m_out);
      end
      if (pd_valid === 1'b1 && first < 0) first = n - base;
    end
    checks++;
    if (first != 6) begin
      failures++;
      $display("FAIL reset_first_pulse: edge=%0d expected 6", first);
    end
  endtask

  task automatic run_const(input string name, input int off,
                           input int e0, input int ek);
    int pv [$];
    int pe [$];
    int base;
    tick(0, 0, 0, 1'b0, 1'b1);
    base = n;
    for (int i = 0; i < 18; i++) begin
      tick(20, 20, off, 1'b0, 1'b0);
      checks++;
      if (pd_valid !== m_valid || pd_out !== PW'(m_out)) begin
        failures++;
        $display("FAIL %s_model: pd_valid=%0b pd_out=%0d expected %0b %0d",
                 name, pd_valid, pd_out, m_valid, m_out);
      end
      if (pd_valid === 1'b1) begin
        pv.push_back(int'(pd_out));
        pe.push_back(n - base);
      end
    end
    checks++;
    if (pv.size() != 4) begin
      failures++;
      $display("FAIL %s_pulses: count=%0d expected 4", name, pv.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (pv[i] != (i == 0 ? e0 : ek) || pe[i] != 6 + 4 * i) begin
          failures++;
          $display("FAIL %s_window%0d: pd_out=%0d at %0d expected %0d at %0d",
                   name, i, pv[i], pe[i], (i == 0 ? e0 : ek), 6 + 4 * i);
        end
      end
    end
  endtask

  task automatic test_step();
    int pv [$];
    int exp_v [3] = '{0, 20, 0};
    tick(0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) begin
      if (i < 4) tick(40, 40, 0, 1'b0, 1'b0);
      else tick(-20, -20, 0, 1'b0, 1'b0);
      checks++;
      if (pd_valid !== m_valid || pd_out !== PW'(m_out)) begin
        failures++;
        $display("FAIL step_model: pd_valid=%0b pd_out=%0d expected %0b %0d",
                 pd_valid, pd_out, m_valid, m_out);
      end
      if (pd_valid === 1'b1) pv.push_back(int'(pd_out));
    end
    checks++;
    if (pv.size() != 3) begin
      failures++;
      $display("FAIL step_pulses: count=%0d expected 3", pv.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (pv[i] != exp_v[i]) begin
          failures++;
          $display("FAIL step_window%0d: pd_out=%0d expected %0d",
                   i, pv[i], exp_v[i]);
        end
      end
    end
  endtask

  task automatic test_hold();
    int pv [$];
    int pe [$];
    int base;
    int exp_v [3] = '{21, 21, 24};
    int exp_e [3] = '{6, 13, 17};
    tick(0, 0, 0, 1'b0, 1'b1);
    base = n;
    for (int i = 0; i < 17; i++) begin
      tick(20, 20, 3, (i >= 6 && i <= 8), 1'b0);
      checks++;
      if (pd_valid !== m_valid || pd_out !== PW'(m_out)) begin
        failures++;
        $display("FAIL hold_model: pd_valid=%0b pd_out=%0d expected %0b %0d",
                 pd_valid, pd_out, m_valid, m_out);
      end
      if (pd_valid === 1'b1) begin
        pv.push_back(int'(pd_out));
        pe.push_back(n - base);
      end
    end
    checks++;
    if (pv.size() != 3) begin
      failures++;
      $display("FAIL hold_pulses: count=%0d expected 3", pv.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (pv[i] != exp_v[i] || pe[i] != exp_e[i]) begin
          failures++;
          $display("FAIL hold_window%0d: pd_out=%0d at %0d expected %0d at %0d",
                   i, pv[i], pe[i], exp_v[i], exp_e[i]);
        end
      end
    end
  endtask

  task automatic test_extreme();
    int pv [$];
    int pe [$];
    int base;
    int exp_v [4] = '{-896, -1024, -1024, -896};
    int exp_e [4] = '{6, 10, 14, 21};
    tick(0, 0, 0, 1'b0, 1'b1);
    base = n;
    for (int i = 0; i < 21; i++) begin
      tick(-128, -128, -128, 1'b0, (i == 14));
      checks++;
      if (pd_valid !== m_valid || pd_out !== PW'(m_out)) begin
        failures++;
        $display("FAIL extreme_model: pd_valid=%0b pd_out=%0d expected %0b %0d",
                 pd_valid, pd_out, m_valid, m_out);
      end
      if (pd_valid === 1'b1) begin
        pv.push_back(int'(pd_out));
        pe.push_back(n - base);
      end
    end
    checks++;
    if (pv.size() != 4) begin
      failures++;
      $display("FAIL extreme_pulses: count=%0d expected 4", pv.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (pv[i] != exp_v[i] || pe[i] != exp_e[i]) begin
          failures++;
          $display("FAIL extreme_window%0d: pd_out=%0d at %0d expected %0d at %0d",
                   i, pv[i], pe[i], exp_v[i], exp_e[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    bit h, r;
    int pulses;
    bit prev;
    pulses = 0;
    prev = 0;
    tick(0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      h = ($urandom_range(7) == 0);
      r = ($urandom_range(63) == 0);
      tick(rnd8(), rnd8(), rnd8(), h, r);
      checks++;
      if (pd_valid !== m_valid || pd_out !== PW'(m_out)) begin
        failures++;
        $display("FAIL random_model: cyc=%0d pd_valid=%0b pd_out=%0d expected %0b %0d",
                 i, pd_valid, pd_out, m_valid, m_out);
      end
      if (pd_valid === 1'b1 && prev) begin
        failures++;
        $display("FAIL random_back_to_back: cyc=%0d pd_valid=1 expected 0", i);
      end
      prev = (pd_valid === 1'b1);
      if (prev) pulses++;
    end
    checks++;
    if (pulses < 20) begin
      failures++;
      $display("FAIL random_activity: pulses=%0d expected >= 20", pulses);
    end
  endtask

  initial begin
    clk = 0;
    rst = 1;
    hold = 0;
    pd_offset = '0;
    din[0] = '0;
    din[1] = '0;
    m_acc = 0;
    m_cnt = 0;
    m_hist = 0;
    m_hv = 0;
    m_valid = 0;
    m_out = 0;
    test_reset();
    run_const("const", 0, 0, 0);
    run_const("offset", 3, 21, 24);
    test_step();
    test_hold();
    test_extreme();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pd_main_mm.md
Name: pd_main_mm

Overview:
- Main Mueller-Muller phase detector for the CDR loop, and the consumer of the auxiliary-PD `pd_offset` word.
- Takes Nti time-interleaved ADC samples per parallel clock and computes a sign-data MM term per slice.
- Adds `pd_offset` per slice, sums across slices, and accumulates over a window of 2**Nacc words.
- Presents a signed phase-error word with a one-cycle valid strobe to the digital loop filter.

Parameters:
- Nadc, 8: ADC sample width (signed).
- Nti, 1: slices per parallel word.
- Nacc, 4: log2 of words per accumulation window.

Ports:
- clk  in  1  parallel data clock.
- rst  in  1  synchronous reset, active-high.
- din  in  Nadc x Nti (signed, unpacked [Nti-1:0])  ADC samples; slice 0 is earliest in time.
- pd_offset  in  Nadc (signed)  phase offset added once per slice term.
- hold  in  1  discard the current word; counting and accumulation freeze.
- pd_out  out  Npd (signed)  window-summed phase error; Npd = Nadc+2+$clog2(Nti)+Nacc.
- pd_valid  out  1  one-cycle pulse when pd_out updates.

Behaviour:
- Single clock domain. All state is reset synchronously on the rst edge: pd_out=0, pd_valid=0, accumulator=0, word counter=0, history-valid=0, pipeline valids=0.
- Decision rule: a(y)=1 when y>=0, else 0.
- Slice term, with yp = previous-in-time sample (slice k-1, or the previous word's slice Nti-1 for k=0):
  - t_k = (a(yp) ? y_k : -y_k) - (a(y_k) ? yp : -yp) + pd_offset
  - Computed in Nadc+2 signed bits; range [-384,383] at Nadc=8, so no saturation is needed.
- Slice 0 history:
  - When history-valid=0, t_0 is forced to 0 (offset is not added either).
  - history-valid is set after any accepted word and cleared by rst or by a held word.
- Stage 1 (edge E):
  - Register din, pd_offset and hist (the last slice of the previous accepted word).
  - Register v1 = !hold.
  - hist updates only when hold=0.
- Stage 2 (edge E+1): wsum = sum of t_k, width Nadc+2+$clog2(Nti); v2 <= v1.
- Stage 3 (edge E+2), only when v2=1:
  - If cnt != 2**Nacc-1: acc <= acc + wsum; cnt <= cnt + 1; pd_valid <= 0.
  - If cnt == 2**Nacc-1: pd_out <= acc + wsum; acc <= 0; cnt <= 0; pd_valid <= 1.
- When v2=0: acc and cnt hold and pd_valid <= 0.
- Latency: the last word of a window is sampled at edge E; pd_valid is high in the cycle after edge E+2. pd_valid is never high two cycles in a row when Nacc>=1.
- pd_out holds its value between pulses.
- Nacc=0: every accepted word produces a pd_valid pulse.
- Reset mid-window: the partial window is discarded, with no pulse. The next window spans 2**Nacc accepted words after reset.
- hold mid-window: the window is stretched by the number of held words, and the first word after the hold has t_0=0.
- Simultaneous rst and hold: rst wins.
- The accumulator cannot overflow at Npd width; no wrap handling is required.

Decomposition:
- Package `pd_pkg`:
  - function `pd_term_w(Nadc)` returning Nadc+2;
  - function `pd_out_w(Nadc,Nti,Nacc)` returning Npd;
  - localparam for the decision threshold (0).
- Sub-module `pd_mm_slice` (combinational, one per slice via generate):
  - inputs y, yp, yp_valid, offset;
  - output t (signed, Nadc+2).
- Top level holds the pipeline, adder tree, counter and accumulator.

Test Plan:
1. Reset: rst=1 for 2 cycles with random din -> pd_out=0, pd_valid=0; no pulse until 4 accepted words have passed three stages. (Nti=2, Nacc=2 unless stated.)
2. din={+20,+20} constant, pd_offset=0 -> pd_valid every 4th cycle, pd_out=0.
3. din constant {+20,+20}, pd_offset=+3 -> first window pd_out=21 (slice 0 of word 0 excluded), every later window pd_out=24.
4. Step: window 1 din={+40,+40}; window 2 din={-20,-20}, pd_offset=0 -> window 1 pd_out=0 (plus 0 from the excluded slice), window 2 pd_out=+20, window 3 pd_out=0.
5. hold=1 for 3 cycles after word 2 of a window, constant {+20,+20}, pd_offset=+3 -> that window's pulse is delayed 3 cycles, pd_out=21; the next window is 24.
6. Extremes: din={-128,-128}, pd_offset=-128 -> steady-state pd_out=-1024 with no overflow. Then assert rst at cnt=2 -> no pulse; the next pulse comes 4 words after rst is released, pd_out=-896 (first slice excluded).
